// File: rtl/dff_pipe_if.sv
// Bundle for the dff_pipe delay line: control, input word and pipe outputs.
// With DFF_PIPE_PARITY_EN defined, the bundle also carries par_flip and parity_err.
interface dff_pipe_if #(
   parameter int WIDTH = 4,
   parameter int DEPTH = 3
) ();
   localparam int CW = $clog2(DEPTH + 1);

   logic             en;
   logic             flush;
   logic [WIDTH-1:0] d;
   logic             d_valid;
   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] qb;
   logic             q_valid;
   logic [CW-1:0]    count;
`ifdef DFF_PIPE_PARITY_EN
   logic             par_flip;
   logic             parity_err;
`endif

   // upstream driver side
   modport master (
      output en, flush, d, d_valid,
`ifdef DFF_PIPE_PARITY_EN
      output par_flip,
      input  parity_err,
`endif
      input  q, qb, q_valid, count
   );

   // delay-line side
   modport slave (
      input  en, flush, d, d_valid,
`ifdef DFF_PIPE_PARITY_EN
      input  par_flip,
      output parity_err,
`endif
      output q, qb, q_valid, count
   );
endinterface

// File: rtl/dff_pipe.sv
// WIDTH-bit, DEPTH-stage delay line with complementary outputs, valid tracking,
// stall, flush and occupancy count. Optional per-stage parity: DFF_PIPE_PARITY_EN.
module dff_pipe #(
   parameter int               WIDTH     = 4,
   parameter int               DEPTH     = 3,
   parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
   input logic       clk,
   input logic       reset,
   dff_pipe_if.slave pif
);
   localparam int CW = $clog2(DEPTH + 1);

   function automatic logic parity_of(input logic [WIDTH-1:0] v);
      return ^v;
   endfunction

   logic [WIDTH-1:0] stage_r [DEPTH];
   logic [DEPTH-1:0] valid_r;
   logic [CW-1:0]    count_r;
   logic [CW-1:0]    count_shift_s;

   // Modular arithmetic is safe: count only exceeds DEPTH transiently when the last stage drains.
   assign count_shift_s = count_r + CW'(pif.d_valid) - CW'(valid_r[DEPTH-1]);

   // Stage data, valid bits and occupancy: reset > flush > shift > hold
   always_ff @(posedge clk) begin
      if (!reset || pif.flush) begin
         for (int i = 0; i < DEPTH; i++) begin
            stage_r[i] <= RESET_VAL;
         end
         valid_r <= {DEPTH{1'b0}};
         count_r <= {CW{1'b0}};
      end else if (pif.en) begin
         stage_r[0] <= pif.d;
         valid_r[0] <= pif.d_valid;
         for (int i = 1; i < DEPTH; i++) begin
            stage_r[i] <= stage_r[i-1];
            valid_r[i] <= valid_r[i-1];
         end
         count_r <= count_shift_s;
      end else begin
         count_r <= count_r;
      end
   end

   // q and qb share one register so X propagates identically to both
   assign pif.q       = stage_r[DEPTH-1];
   assign pif.qb      = ~stage_r[DEPTH-1];
   assign pif.q_valid = valid_r[DEPTH-1];
   assign pif.count   = count_r;

`ifdef DFF_PIPE_PARITY_EN
   logic [DEPTH-1:0] par_r;

   // Parity travels alongside the data; par_flip corrupts it at capture
   always_ff @(posedge clk) begin
      if (!reset || pif.flush) begin
         par_r <= {DEPTH{parity_of(RESET_VAL)}};
      end else if (pif.en) begin
         par_r[0] <= parity_of(pif.d) ^ pif.par_flip;
         for (int i = 1; i < DEPTH; i++) begin
            par_r[i] <= par_r[i-1];
         end
      end else begin
         par_r <= par_r;
      end
   end

   assign pif.parity_err = pif.q_valid & (parity_of(stage_r[DEPTH-1]) != par_r[DEPTH-1]);
`endif
endmodule
